// File: rtl/memory_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency unified memory between the
// instruction-fetch port and the load/store port.
module memory_port_arbiter #(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_address,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_ready,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic FETCH = 1'b0;
  localparam logic DATA  = 1'b1;

  localparam logic [3:0] LAST_CNT = 4'(MEM_LATENCY - 1);

  logic [1:0] state;
  logic       owner;
  logic       last_grant;
  logic [3:0] cnt;
  logic       grant_valid;
  logic       grant_sel;

  // On a conflict the port that did not win last time gets the memory.
  always_comb begin
    grant_valid = if_req | dm_req;
    if (if_req && dm_req) begin
      grant_sel = ~last_grant;
    end else if (dm_req) begin
      grant_sel = DATA;
    end else begin
      grant_sel = FETCH;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= FETCH;
      last_grant  <= FETCH;
      cnt         <= 4'd0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      if_ready    <= 1'b0;
      dm_ready    <= 1'b0;
      if_rdata    <= '0;
      dm_rdata    <= '0;
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            state      <= BUSY;
            owner      <= grant_sel;
            last_grant <= grant_sel;
            cnt        <= 4'd0;
            mem_en     <= 1'b1;
            if (grant_sel == DATA) begin
              mem_we      <= dm_we;
              mem_address <= dm_address;
              mem_wdata   <= dm_wdata;
            end else begin
              mem_we      <= 1'b0;
              mem_address <= if_address;
              mem_wdata   <= '0;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 4'd1;
          // Last BUSY cycle: memory data is valid now, so loads capture it here.
          if (cnt == LAST_CNT) begin
            state  <= RESP;
            mem_we <= 1'b0;
            if (owner == DATA) begin
              dm_ready <= 1'b1;
              if (!mem_we) begin
                dm_rdata <= mem_rdata;
              end
            end else begin
              if_ready <= 1'b1;
              if (!mem_we) begin
                if_rdata <= mem_rdata;
              end
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomised bench for memory_port_arbiter at MEM_LATENCY 2 and 1, checked
// against a transaction-timing reference model.
module tb_memory_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  logic          if_req      [2];
  logic [AW-1:0] if_address  [2];
  logic          if_ready    [2];
  logic [DW-1:0] if_rdata    [2];
  logic          dm_req      [2];
  logic          dm_we       [2];
  logic [AW-1:0] dm_address  [2];
  logic [DW-1:0] dm_wdata    [2];
  logic          dm_ready    [2];
  logic [DW-1:0] dm_rdata    [2];
  logic          mem_en      [2];
  logic          mem_we      [2];
  logic [AW-1:0] mem_address [2];
  logic [DW-1:0] mem_wdata   [2];
  logic [DW-1:0] mem_rdata   [2];
  logic          busy        [2];

  int lat [2] = '{2, 1};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    memory_port_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MEM_LATENCY(g == 0 ? 2 : 1)
    ) dut (
      .clock      (clock),
      .reset      (reset),
      .if_req     (if_req[g]),
      .if_address (if_address[g]),
      .if_ready   (if_ready[g]),
      .if_rdata   (if_rdata[g]),
      .dm_req     (dm_req[g]),
      .dm_we      (dm_we[g]),
      .dm_address (dm_address[g]),
      .dm_wdata   (dm_wdata[g]),
      .dm_ready   (dm_ready[g]),
      .dm_rdata   (dm_rdata[g]),
      .mem_en     (mem_en[g]),
      .mem_we     (mem_we[g]),
      .mem_address(mem_address[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_rdata  (mem_rdata[g]),
      .busy       (busy[g])
    );
  end

  // Reference model: one transaction in flight, described by its grant cycle.
  bit          act      [2];
  int          gcyc     [2];
  bit          own      [2];
  bit          twe      [2];
  logic [63:0] taddr    [2];
  logic [63:0] twd      [2];
  bit          lastg    [2];
  logic [63:0] exp_ifr  [2];
  logic [63:0] exp_dmr  [2];
  bit          fresh    [2];
  bit          done_f   [2];
  bit          done_d   [2];

  bit checking = 1'b0;
  int cyc = 0;
  int passed = 0;
  int failed = 0;
  int total = 0;

  task automatic check(input string tag, input int i, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s L=%0d cyc=%0d observed=%h expected=%h", tag, lat[i], cyc, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int i);
    if (if_req[i] === 1'b1 && !done_f[i]) begin
      if ($urandom_range(0, 7) == 0) if_req[i] = 1'b0;
    end else begin
      if_req[i]     = 1'($urandom_range(0, 1));
      if_address[i] = 64'($urandom_range(0, 255)) << 3;
    end
    if (dm_req[i] === 1'b1 && !done_d[i]) begin
      if ($urandom_range(0, 7) == 0) dm_req[i] = 1'b0;
    end else begin
      dm_req[i]     = 1'($urandom_range(0, 1));
      dm_we[i]      = 1'($urandom_range(0, 1));
      dm_address[i] = 64'($urandom_range(0, 255)) << 3;
      dm_wdata[i]   = {$urandom, $urandom};
    end
    done_f[i]    = 1'b0;
    done_d[i]    = 1'b0;
    mem_rdata[i] = {$urandom, $urandom};
  endtask

  task automatic checkOutput(input int i);
    bit in_busy;
    bit in_resp;
    if (!checking) return;
    in_busy = act[i] && (cyc >= gcyc[i] + 1) && (cyc <= gcyc[i] + lat[i]);
    in_resp = act[i] && (cyc == gcyc[i] + lat[i] + 1);
    check("busy",     i, 64'(busy[i]),     64'(in_busy || in_resp));
    check("mem_en",   i, 64'(mem_en[i]),   64'(act[i] && cyc == gcyc[i] + 1));
    check("if_ready", i, 64'(if_ready[i]), 64'(in_resp && !own[i]));
    check("dm_ready", i, 64'(dm_ready[i]), 64'(in_resp && own[i]));
    check("if_rdata", i, if_rdata[i], exp_ifr[i]);
    check("dm_rdata", i, dm_rdata[i], exp_dmr[i]);
    if (in_busy) begin
      check("mem_we",      i, 64'(mem_we[i]), 64'(twe[i]));
      check("mem_address", i, mem_address[i], taddr[i]);
      if (twe[i]) check("mem_wdata", i, mem_wdata[i], twd[i]);
    end
    if (fresh[i]) begin
      check("idle_mem_we",      i, 64'(mem_we[i]), 64'd0);
      check("idle_mem_address", i, mem_address[i], 64'd0);
      check("idle_mem_wdata",   i, mem_wdata[i],   64'd0);
    end
  endtask

  task automatic updateModel(input int i);
    if (reset) begin
      act[i]     = 1'b0;
      lastg[i]   = 1'b0;
      exp_ifr[i] = '0;
      exp_dmr[i] = '0;
      fresh[i]   = 1'b1;
    end else if (act[i]) begin
      if (cyc == gcyc[i] + lat[i] && !twe[i]) begin
        if (own[i]) exp_dmr[i] = mem_rdata[i];
        else        exp_ifr[i] = mem_rdata[i];
      end
      if (cyc == gcyc[i] + lat[i] + 1) begin
        act[i] = 1'b0;
        if (own[i]) done_d[i] = 1'b1;
        else        done_f[i] = 1'b1;
      end
    end else if (if_req[i] || dm_req[i]) begin
      own[i]   = (if_req[i] && dm_req[i]) ? !lastg[i] : dm_req[i];
      lastg[i] = own[i];
      act[i]   = 1'b1;
      gcyc[i]  = cyc;
      fresh[i] = 1'b0;
      if (own[i]) begin
        twe[i]   = dm_we[i];
        taddr[i] = dm_address[i];
        twd[i]   = dm_wdata[i];
      end else begin
        twe[i]   = 1'b0;
        taddr[i] = if_address[i];
        twd[i]   = '0;
      end
    end
  endtask

  initial begin
    $display("[TB] starting memory_port_arbiter random run");
    for (int i = 0; i < 2; i++) begin
      if_req[i]     = 1'b1;
      if_address[i] = 64'h10;
      dm_req[i]     = 1'b1;
      dm_we[i]      = 1'b0;
      dm_address[i] = 64'h100;
      dm_wdata[i]   = 64'hDEADBEEF;
      mem_rdata[i]  = '0;
    end
    // Reset for two cycles with both requests high; first grant goes to data.
    for (int c = 1; c <= 3000; c++) begin
      @(posedge clock);
      #1;
      cyc = c;
      if (c <= 3) begin
        reset = (c <= 2);
        for (int i = 0; i < 2; i++) mem_rdata[i] = {$urandom, $urandom};
      end else begin
        reset = ($urandom_range(0, 99) == 0);
        for (int i = 0; i < 2; i++) applyStimulus(i);
      end
      if (c == 2) checking = 1'b1;
      @(negedge clock);
      for (int i = 0; i < 2; i++) checkOutput(i);
      for (int i = 0; i < 2; i++) updateModel(i);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
# memory_port_arbiter

Shares one single-ported, fixed-latency unified memory between the processor's instruction-fetch path and its load/store path. Each requester uses a req/ready handshake. The arbiter serialises accesses with round-robin priority, drives the memory port, and returns read data to the granted requester. It sits between the program counter / instruction decode logic and the data memory, and replaces the separate instruction and data memories.

## Interface
- `ADDR_WIDTH`, default 64: byte address width.
- `DATA_WIDTH`, default 64: memory word width.
- `MEM_LATENCY`, default 2: cycles from issue to valid `mem_rdata`. Legal range is 1..15.

- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_address`  in  ADDR_WIDTH  fetch address; stable while `if_req`.
- `if_ready`  out  1  one-cycle completion pulse for fetch.
- `if_rdata`  out  DATA_WIDTH  fetched word, valid while `if_ready`=1.
- `dm_req`  in  1  load/store request; held until `dm_ready`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_address`  in  ADDR_WIDTH  load/store address.
- `dm_wdata`  in  DATA_WIDTH  store data.
- `dm_ready`  out  1  one-cycle completion pulse for data port.
- `dm_rdata`  out  DATA_WIDTH  load data, valid while `dm_ready`=1.
- `mem_en`  out  1  issue strobe; high for exactly the first BUSY cycle.
- `mem_we`  out  1  write enable; held for the entire BUSY phase.
- `mem_address`  out  ADDR_WIDTH  held for the entire BUSY phase.
- `mem_wdata`  out  DATA_WIDTH  held for the entire BUSY phase.
- `mem_rdata`  in  DATA_WIDTH  valid in the last BUSY cycle.
- `busy`  out  1  high when state is not IDLE.

## Operation
- FSM states: IDLE, BUSY, RESP.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - If exactly one request is pending, grant it.
  - If both are pending, grant the port not recorded in `last_grant`.
  - On grant, register owner, address, `we` and `wdata` into the memory-side outputs, set `last_grant` to the owner, clear `cnt`, and go to BUSY.
- **BUSY:**
  - `mem_en`=1 in the first BUSY cycle only.
  - `cnt` increments each cycle.
  - In the cycle where `cnt` = MEM_LATENCY-1:
    - On a read, capture `mem_rdata` into the owner's rdata register.
    - Go to RESP.
  - BUSY therefore lasts exactly MEM_LATENCY cycles.
- **RESP:**
  - The owner's ready is 1 for this single cycle. The other port's ready stays 0.
  - Requests are not sampled in RESP.
  - Next state is always IDLE.
- **Stores:** the rdata register of the owner is not updated. It keeps its previous value and the ready pulse still occurs.
- **Request withdrawal:**
  - Deasserting req before it is granted has no effect.
  - Deasserting req after grant does not abort. The access completes and ready pulses.
- **Held requests:** a requester still asserting req in the RESP cycle is treated as a new request in the following IDLE cycle. A held fetch is therefore re-fetched, so requesters drop or change req on the ready cycle.
- **Reset values:**
  - State is IDLE.
  - `last_grant` is FETCH, so the first conflict goes to the data port.
  - `cnt`=0.
  - All outputs are 0, including both rdata registers.
- **Reset mid-transaction:** in BUSY or RESP, reset aborts the access. No ready pulse is produced, and `mem_en` and `mem_we` go to 0 in the next cycle.

## Timing
- Request sampled in IDLE at cycle N.
- BUSY spans cycles N+1 .. N+MEM_LATENCY, with `mem_en` asserted at N+1.
- Ready pulses at N+MEM_LATENCY+1.
- The next grant is possible at N+MEM_LATENCY+2.
- Peak throughput is one access per MEM_LATENCY+2 cycles.
- Both ready outputs and both rdata outputs are registered. There is no combinational path from any req input to any output.
- `busy` = 1 in BUSY and RESP. Upstream stall logic uses it.
- Boundary case MEM_LATENCY=1: BUSY is a single cycle, in which `mem_en` is high and `mem_rdata` is captured.

## Test plan
- **Reset:** assert reset 2 cycles with both reqs high -> all outputs 0 during and 1 cycle after reset. First grant is to data.
- **Single fetch, MEM_LATENCY=2:** `if_req` at cycle 5 with addr 0x10; model returns 0x00500093 at cycle 7 -> `mem_en` only at cycle 6, `mem_address`=0x10 at cycles 6-7, `if_ready`=1 with `if_rdata`=0x00500093 at cycle 8 only.
- **Conflict round-robin:** both reqs held continuously, re-asserted after each ready -> grant order D,F,D,F. Each ready is 4 cycles apart, and the ready pulses never overlap.
- **Store:** `dm_we`=1, addr 0x100, wdata 0xDEADBEEF -> `mem_we`=1 and `mem_wdata`=0xDEADBEEF held for 2 cycles. `dm_ready` pulses, `dm_rdata` keeps its prior load value, `if_ready` stays 0.
- **Withdrawal:** `dm_req` dropped one cycle after grant -> access completes and `dm_ready` still pulses at N+3. A fetch pending meanwhile is granted at N+4.
- **Reset mid-access:** reset in the second BUSY cycle -> no ready. Next cycle is IDLE with all outputs 0, and a following fetch completes normally with 3-cycle latency. Repeat the single-fetch check with MEM_LATENCY=1: ready at N+2.
